// File: rtl/ctrl_class_encoder.sv
// Passive monitor beside the main control decoder. Each retiring instruction's
// control vector is mapped back to its opcode and instruction class. Vectors the
// decoder never produces are flagged as illegal. The monitor keeps saturating
// per-class statistics and queues the encoded records for a trace consumer,
// which drains them over a valid/ready port.
module ctrl_class_encoder #(
   parameter int DEPTH = 8,   // FIFO entries, power of two, at least 2
   parameter int CNT_W = 16,  // width of each statistics counter
   parameter int PC_W  = 32   // width of the PC tag
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic                       reg_dst,
   input  logic                       alu_src,
   input  logic                       mem_to_reg,
   input  logic                       reg_write,
   input  logic                       mem_read,
   input  logic                       mem_write,
   input  logic                       branch,
   input  logic [1:0]                 alu_op,
   input  logic [PC_W-1:0]            pc,
   input  logic                       clr_cnts,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [5:0]                 out_opcode,
   output logic [2:0]                 out_class,
   output logic                       out_illegal,
   output logic [PC_W-1:0]            out_pc,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       fifo_full,
   output logic [CNT_W-1:0]           cnt_r,
   output logic [CNT_W-1:0]           cnt_lw,
   output logic [CNT_W-1:0]           cnt_sw,
   output logic [CNT_W-1:0]           cnt_beq,
   output logic [CNT_W-1:0]           cnt_illegal,
   output logic [CNT_W-1:0]           drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);
   localparam int REC_W = 6 + 3 + 1 + PC_W;   // {opcode, class, illegal, pc}
   localparam int N_CLS = 5;                  // R, LW, SW, BEQ, illegal

   // Control vectors the decoder produces, ordered
   // {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op}
   localparam logic [8:0] VEC_R   = 9'b1_0_0_1_0_0_0_10;
   localparam logic [8:0] VEC_LW  = 9'b0_1_1_1_1_0_0_00;
   localparam logic [8:0] VEC_SW  = 9'b0_1_0_0_0_1_0_00;
   localparam logic [8:0] VEC_BEQ = 9'b0_0_0_0_0_0_1_01;

   localparam logic [5:0] OP_R   = 6'd0;
   localparam logic [5:0] OP_LW  = 6'd35;
   localparam logic [5:0] OP_SW  = 6'd43;
   localparam logic [5:0] OP_BEQ = 6'd4;
   localparam logic [5:0] OP_ILL = 6'd63;

   typedef enum logic [2:0] {
      CLS_R   = 3'd0,
      CLS_LW  = 3'd1,
      CLS_SW  = 3'd2,
      CLS_BEQ = 3'd3,
      CLS_ILL = 3'd7
   } class_e;

   logic [8:0]       ctrl_vec;
   logic [5:0]       enc_opcode;
   class_e           enc_class;
   logic             enc_illegal;
   logic [N_CLS-1:0] cls_hit;
   logic [REC_W-1:0] rec_in;

   logic             push;
   logic             pop;
   logic             fifo_empty;
   logic             full_int;

   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [LVL_W-1:0] level_reg, level_next;
   logic [REC_W-1:0] out_rec_reg, out_rec_next;
   logic [REC_W-1:0] head_src;
   logic [REC_W-1:0] mem_reg [DEPTH];

   logic [CNT_W-1:0] cnt_val [N_CLS];
   logic [CNT_W-1:0] drop_reg;

   assign ctrl_vec = {reg_dst, alu_src, mem_to_reg, reg_write,
                      mem_read, mem_write, branch, alu_op};

   // Reverse-decode the exact control vector; anything unrecognised is illegal
   always_comb begin
      enc_opcode  = OP_ILL;
      enc_class   = CLS_ILL;
      enc_illegal = 1'b1;
      case (ctrl_vec)
         VEC_R: begin
            enc_opcode  = OP_R;
            enc_class   = CLS_R;
            enc_illegal = 1'b0;
         end
         VEC_LW: begin
            enc_opcode  = OP_LW;
            enc_class   = CLS_LW;
            enc_illegal = 1'b0;
         end
         VEC_SW: begin
            enc_opcode  = OP_SW;
            enc_class   = CLS_SW;
            enc_illegal = 1'b0;
         end
         VEC_BEQ: begin
            enc_opcode  = OP_BEQ;
            enc_class   = CLS_BEQ;
            enc_illegal = 1'b0;
         end
         default: ;
      endcase
   end

   // One-hot select of the statistics counter belonging to the decoded class
   always_comb begin
      cls_hit = '0;
      case (enc_class)
         CLS_R:   cls_hit[0] = 1'b1;
         CLS_LW:  cls_hit[1] = 1'b1;
         CLS_SW:  cls_hit[2] = 1'b1;
         CLS_BEQ: cls_hit[3] = 1'b1;
         default: cls_hit[4] = 1'b1;
      endcase
   end

   assign rec_in = {enc_opcode, enc_class, enc_illegal, pc};

   // Occupancy is tracked explicitly, so full and empty come straight from it
   assign fifo_empty = (level_reg == '0);
   assign full_int   = (level_reg == LVL_W'(DEPTH));

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
   assign pop  = !fifo_empty && out_ready;
   assign push = in_valid && (!full_int || pop);

   // Pointer and occupancy update, plus selection of the head after this edge
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      level_next  = level_reg;
      if (push) begin
         wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   level_next = level_reg + LVL_W'(1);
         2'b01:   level_next = level_reg - LVL_W'(1);
         default: level_next = level_reg;
      endcase
      // The new record lands in the head slot only when the FIFO is empty after
      // any pop. Otherwise the head is already in storage.
      if (push && (wr_ptr_reg == rd_ptr_next)) begin
         head_src = rec_in;
      end else begin
         head_src = mem_reg[rd_ptr_next];
      end
      // When the FIFO drains, the output register keeps the last head shown
      if (level_next != '0) begin
         out_rec_next = head_src;
      end else begin
         out_rec_next = out_rec_reg;
      end
   end

   // Record storage; the contents need no reset because the output register
   // masks them until they are written
   always_ff @(posedge clk) begin
      if (push) begin
         mem_reg[wr_ptr_reg] <= rec_in;
      end
   end

   // FIFO control state and the registered head record
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         level_reg   <= '0;
         out_rec_reg <= '0;
      end else begin
         wr_ptr_reg  <= wr_ptr_next;
         rd_ptr_reg  <= rd_ptr_next;
         level_reg   <= level_next;
         out_rec_reg <= out_rec_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_CLS; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_reg;

         // Saturating count of every valid sample of this class, dropped or not
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_reg <= '0;
            end else if (clr_cnts) begin
               cnt_reg <= '0;
            end else if (in_valid && cls_hit[gi] && (cnt_reg != '1)) begin
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
         end

         assign cnt_val[gi] = cnt_reg;
      end
   endgenerate

   // Saturating count of samples lost because the FIFO was full with no pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_reg <= '0;
      end else if (clr_cnts) begin
         drop_reg <= '0;
      end else if (in_valid && !push && (drop_reg != '1)) begin
         drop_reg <= drop_reg + CNT_W'(1);
      end
   end

   assign out_valid   = !fifo_empty;
   assign out_opcode  = out_rec_reg[REC_W-1 -: 6];
   assign out_class   = out_rec_reg[PC_W+1 +: 3];
   assign out_illegal = out_rec_reg[PC_W];
   assign out_pc      = out_rec_reg[PC_W-1:0];
   assign level       = level_reg;
   assign fifo_full   = full_int;

   assign cnt_r       = cnt_val[0];
   assign cnt_lw      = cnt_val[1];
   assign cnt_sw      = cnt_val[2];
   assign cnt_beq     = cnt_val[3];
   assign cnt_illegal = cnt_val[4];
   assign drop_cnt    = drop_reg;

endmodule

// File: tb/tb_ctrl_class_encoder.sv
// Bench for ctrl_class_encoder: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_ctrl_class_encoder;

   localparam int DEPTH = 8;
   localparam int CNT_W = 4;
   localparam int PC_W  = 32;
   localparam int CMAX  = (1 << CNT_W) - 1;

   localparam bit [8:0] V_R   = 9'b100100010;
   localparam bit [8:0] V_LW  = 9'b011110000;
   localparam bit [8:0] V_SW  = 9'b010001000;
   localparam bit [8:0] V_BEQ = 9'b000000101;
   localparam bit [8:0] V_ILL = 9'h1FF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic reg_dst = 1'b0, alu_src = 1'b0, mem_to_reg = 1'b0, reg_write = 1'b0;
   logic mem_read = 1'b0, mem_write = 1'b0, branch = 1'b0;
   logic [1:0] alu_op = 2'd0;
   logic [PC_W-1:0] pc = '0;
   logic clr_cnts = 1'b0;
   logic out_ready = 1'b0;

   logic out_valid, out_illegal, fifo_full;
   logic [5:0] out_opcode;
   logic [2:0] out_class;
   logic [PC_W-1:0] out_pc;
   logic [$clog2(DEPTH+1)-1:0] level;
   logic [CNT_W-1:0] cnt_r, cnt_lw, cnt_sw, cnt_beq, cnt_illegal, drop_cnt;

   always #5 clk = ~clk;

   ctrl_class_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W), .PC_W(PC_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .branch(branch), .alu_op(alu_op), .pc(pc), .clr_cnts(clr_cnts),
      .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
      .out_class(out_class), .out_illegal(out_illegal), .out_pc(out_pc),
      .level(level), .fifo_full(fifo_full), .cnt_r(cnt_r), .cnt_lw(cnt_lw),
      .cnt_sw(cnt_sw), .cnt_beq(cnt_beq), .cnt_illegal(cnt_illegal),
      .drop_cnt(drop_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int          opcode;
      int          cls;
      int          ill;
      logic [31:0] pc;
   } rec_t;

   bit [8:0] legal_vec [4] = '{V_R, V_LW, V_SW, V_BEQ};
   int       legal_op  [4] = '{0, 35, 43, 4};

   rec_t q[$];
   rec_t last_r = '{opcode: 0, cls: 0, ill: 0, pc: 32'd0};
   int   m_cnt [5] = '{0, 0, 0, 0, 0};
   int   m_drop = 0;
   bit   chk_en = 1'b0;

   function automatic rec_t classify(input bit [8:0] v, input logic [31:0] p);
      rec_t r;
      r = '{opcode: 63, cls: 7, ill: 1, pc: p};
      for (int i = 0; i < 4; i++) begin
         if (v == legal_vec[i]) begin
            r.opcode = legal_op[i];
            r.cls    = i;
            r.ill    = 0;
         end
      end
      return r;
   endfunction

   // Model update on each edge (or reset): pop, count, push/drop, clear
   initial begin : model
      rec_t r;
      int   idx;
      bit   do_pop;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            q.delete();
            for (int i = 0; i < 5; i++) m_cnt[i] = 0;
            m_drop = 0;
            last_r = '{opcode: 0, cls: 0, ill: 0, pc: 32'd0};
         end else begin
            do_pop = (q.size() > 0) && out_ready;
            if (do_pop) void'(q.pop_front());
            if (in_valid) begin
               r   = classify({reg_dst, alu_src, mem_to_reg, reg_write,
                               mem_read, mem_write, branch, alu_op}, pc);
               idx = (r.cls == 7) ? 4 : r.cls;
               if (m_cnt[idx] < CMAX) m_cnt[idx]++;
               if (q.size() < DEPTH) q.push_back(r);
               else if (m_drop < CMAX) m_drop++;
            end
            if (clr_cnts) begin
               for (int i = 0; i < 5; i++) m_cnt[i] = 0;
               m_drop = 0;
            end
            if (q.size() > 0) last_r = q[0];
         end
      end
   end

   // Cycle-by-cycle comparison of every output against the model
   initial begin : compare
      forever begin
         @(negedge clk);
         if (rst_n && chk_en) begin
            chk("cyc_out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("cyc_level", 64'(level), 64'(q.size()));
            chk("cyc_fifo_full", 64'(fifo_full), 64'(q.size() == DEPTH));
            chk("cyc_opcode", 64'(out_opcode), 64'(last_r.opcode));
            chk("cyc_class", 64'(out_class), 64'(last_r.cls));
            chk("cyc_illegal", 64'(out_illegal), 64'(last_r.ill));
            chk("cyc_pc", 64'(out_pc), 64'(last_r.pc));
            chk("cyc_cnt_r", 64'(cnt_r), 64'(m_cnt[0]));
            chk("cyc_cnt_lw", 64'(cnt_lw), 64'(m_cnt[1]));
            chk("cyc_cnt_sw", 64'(cnt_sw), 64'(m_cnt[2]));
            chk("cyc_cnt_beq", 64'(cnt_beq), 64'(m_cnt[3]));
            chk("cyc_cnt_illegal", 64'(cnt_illegal), 64'(m_cnt[4]));
            chk("cyc_drop_cnt", 64'(drop_cnt), 64'(m_drop));
         end
      end
   end

   // Apply one cycle of stimulus, then return 1 time unit after the edge
   task automatic drive(input bit v, input bit [8:0] vec, input logic [31:0] p,
                        input bit rdy, input bit clr);
      in_valid  = v;
      {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op} = vec;
      pc        = p;
      out_ready = rdy;
      clr_cnts  = clr;
      @(posedge clk);
      #1;
   endtask

   int exp_op [4] = '{0, 43, 4, 63};
   int exp_il [4] = '{0, 0, 0, 1};

   initial begin : stim
      bit [8:0] vec;
      bit       v, rdy, clr;
      int       sel;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_fifo_full", 64'(fifo_full), 64'd0);
      chk("rst_opcode", 64'(out_opcode), 64'd0);
      chk("rst_pc", 64'(out_pc), 64'd0);
      chk("rst_cnt_r", 64'(cnt_r), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      #2 rst_n = 1'b1;
      chk_en = 1'b1;

      // single LW record, then consume it
      drive(1, V_LW, 32'h100, 0, 0);
      chk("lw_valid", 64'(out_valid), 64'd1);
      chk("lw_opcode", 64'(out_opcode), 64'd35);
      chk("lw_class", 64'(out_class), 64'd1);
      chk("lw_pc", 64'(out_pc), 64'h100);
      chk("lw_cnt", 64'(cnt_lw), 64'd1);
      drive(0, 9'd0, 32'd0, 1, 0);
      chk("lw_pop_valid", 64'(out_valid), 64'd0);
      chk("lw_pop_level", 64'(level), 64'd0);

      // R, SW, BEQ, illegal, then drain in order
      drive(1, V_R, 32'h1, 0, 0);
      drive(1, V_SW, 32'h2, 0, 0);
      drive(1, V_BEQ, 32'h3, 0, 0);
      drive(1, V_ILL, 32'h4, 0, 0);
      chk("seq_level", 64'(level), 64'd4);
      chk("seq_cnt_r", 64'(cnt_r), 64'd1);
      chk("seq_cnt_sw", 64'(cnt_sw), 64'd1);
      chk("seq_cnt_beq", 64'(cnt_beq), 64'd1);
      chk("seq_cnt_ill", 64'(cnt_illegal), 64'd1);
      for (int i = 0; i < 4; i++) begin
         chk("drain_opcode", 64'(out_opcode), 64'(exp_op[i]));
         chk("drain_illegal", 64'(out_illegal), 64'(exp_il[i]));
         drive(0, 9'd0, 32'd0, 1, 0);
      end
      chk("drain_level", 64'(level), 64'd0);

      // fill, overflow, then push+pop at full
      for (int i = 0; i < 8; i++) drive(1, V_SW, 32'h200 + i, 0, 0);
      for (int i = 0; i < 3; i++) drive(1, V_SW, 32'h300 + i, 0, 0);
      chk("full_flag", 64'(fifo_full), 64'd1);
      chk("full_drop", 64'(drop_cnt), 64'd3);
      chk("full_level", 64'(level), 64'd8);
      chk("full_head", 64'(out_pc), 64'h200);
      drive(1, V_SW, 32'h400, 1, 0);
      chk("full_pp_level", 64'(level), 64'd8);
      chk("full_pp_drop", 64'(drop_cnt), 64'd3);
      chk("full_pp_head", 64'(out_pc), 64'h201);
      repeat (8) drive(0, 9'd0, 32'd0, 1, 0);
      chk("full_drained", 64'(level), 64'd0);

      // saturation and clear priority
      drive(0, 9'd0, 32'd0, 1, 1);
      chk("clr_cnt_sw", 64'(cnt_sw), 64'd0);
      chk("clr_drop", 64'(drop_cnt), 64'd0);
      repeat (20) drive(1, V_R, 32'h50, 1, 0);
      chk("sat_cnt_r", 64'(cnt_r), 64'd15);
      drive(0, 9'd0, 32'd0, 1, 0);
      drive(1, V_R, 32'h55, 0, 1);
      chk("clr_pri_cnt_r", 64'(cnt_r), 64'd0);
      chk("clr_pri_level", 64'(level), 64'd1);
      chk("clr_pri_pc", 64'(out_pc), 64'h55);

      // backpressure: head holds for 3 cycles, next entry after one pop
      drive(1, V_LW, 32'h10, 0, 0);
      drive(1, V_SW, 32'h20, 0, 0);
      drive(1, V_BEQ, 32'h30, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 9'd0, 32'd0, 0, 0);
         chk("bp_opcode", 64'(out_opcode), 64'd0);
         chk("bp_class", 64'(out_class), 64'd0);
         chk("bp_pc", 64'(out_pc), 64'h55);
      end
      drive(0, 9'd0, 32'd0, 1, 0);
      chk("bp_next_opcode", 64'(out_opcode), 64'd35);
      chk("bp_next_pc", 64'(out_pc), 64'h10);
      chk("bp_next_level", 64'(level), 64'd3);

      // asynchronous reset mid-cycle with five entries queued
      drive(1, V_ILL, 32'h60, 0, 0);
      drive(1, V_ILL, 32'h61, 0, 0);
      chk("ar_pre_level", 64'(level), 64'd5);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("ar_out_valid", 64'(out_valid), 64'd0);
      chk("ar_level", 64'(level), 64'd0);
      chk("ar_opcode", 64'(out_opcode), 64'd0);
      chk("ar_cnt_lw", 64'(cnt_lw), 64'd0);
      chk("ar_cnt_sw", 64'(cnt_sw), 64'd0);
      chk("ar_cnt_beq", 64'(cnt_beq), 64'd0);
      chk("ar_cnt_ill", 64'(cnt_illegal), 64'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;

      // randomized traffic with alternating light/heavy backpressure
      for (int i = 0; i < 3000; i++) begin
         v   = ($urandom_range(0, 9) < 7);
         sel = $urandom_range(0, 5);
         vec = (sel < 4) ? legal_vec[sel] : 9'($urandom);
         rdy = ((i % 400) < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
         clr = ($urandom_range(0, 49) == 0);
         drive(v, vec, $urandom, rdy, clr);
      end
      drive(0, 9'd0, 32'd0, 0, 0);
      @(negedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
